// File: rtl/seq_detect_param.sv
// seq_detect_param: programmable serial pattern detector.
//
// Shifts accepted serial bits into a history register and flags a match when
// the most recent `len` bits equal the low `len` bits of the loaded pattern.
// Matches may overlap or not, selected by a runtime overlap bit.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high reset; restores default config
//   seq_in       serial data bit
//   in_valid     seq_in is accepted on a rising edge only when high
//   cfg_load     one-cycle strobe latching cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  pattern, bit [len-1] received first, bit [0] received last
//   cfg_len      pattern length (0 -> 1, > PAT_MAX -> PAT_MAX)
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   seq_out      registered match flag, held until next accepted bit
//   match_count  saturating match count since reset or cfg_load
module seq_detect_param #(
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 8,
    parameter logic [PAT_MAX-1:0] DEF_PAT = 8'b0000_0100,
    parameter int unsigned DEF_LEN = 4,
    parameter bit          DEF_OVL = 1'b1,
    localparam int unsigned LEN_W  = $clog2(PAT_MAX + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               seq_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               seq_out,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] LenMax = LEN_W'(PAT_MAX);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0) begin
            return LEN_W'(1);
        end else if (l > LenMax) begin
            return LenMax;
        end else begin
            return l;
        end
    endfunction

    logic [PAT_MAX-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               seq_out_q, seq_out_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PAT_MAX-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;

    logic [PAT_MAX-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [PAT_MAX-1:0] len_mask;
    logic               illegal;
    logic               match;

    always_comb begin
        hist_shift = {hist_q[PAT_MAX-2:0], seq_in};
        fill_inc   = (fill_q >= LenMax) ? LenMax : fill_q + LEN_W'(1);

        // Only the low len bits take part in the comparison.
        len_mask = '0;
        for (int unsigned i = 0; i < PAT_MAX; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end

        // fill beyond PAT_MAX or an out-of-range len can only come from upset state.
        illegal = (fill_q > LenMax) || (len_q == '0) || (len_q > LenMax);

        match = (fill_inc >= len_q) && (((hist_shift ^ pattern_q) & len_mask) == '0);
    end

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        seq_out_d = seq_out_q;
        count_d   = count_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;

        if (cfg_load) begin
            // Config load wins over any bit presented on the same edge.
            pattern_d = cfg_pattern;
            len_d     = clamp_len(cfg_len);
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            seq_out_d = 1'b0;
            count_d   = '0;
        end else if (in_valid) begin
            if (illegal) begin
                hist_d    = '0;
                fill_d    = '0;
                seq_out_d = 1'b0;
                len_d     = clamp_len(len_q);
            end else begin
                hist_d    = hist_shift;
                seq_out_d = match;
                if (match) begin
                    fill_d = overlap_q ? fill_inc : '0;
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    fill_d = fill_inc;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            seq_out_q <= 1'b0;
            count_q   <= '0;
            pattern_q <= DEF_PAT;
            len_q     <= clamp_len(LEN_W'(DEF_LEN));
            overlap_q <= DEF_OVL;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            seq_out_q <= seq_out_d;
            count_q   <= count_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
        end
    end

    assign seq_out     = seq_out_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed testbench for seq_detect_param. A second instance with CNT_W=2
// shares all inputs and is used for the counter saturation check.
module tb_seq_detect_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       seq_in;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       seq_out;
    logic [7:0] match_count;
    logic       seq_out_s;
    logic [1:0] match_count_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    seq_detect_param dut (
        .clock       (clock),
        .reset       (reset),
        .seq_in      (seq_in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .seq_out     (seq_out),
        .match_count (match_count)
    );

    seq_detect_param #(.CNT_W(2)) dut_sat (
        .clock       (clock),
        .reset       (reset),
        .seq_in      (seq_in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .seq_out     (seq_out_s),
        .match_count (match_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one bit (or an idle cycle when v=0); outputs sampled 1 ns after the edge.
    task automatic step(input logic b, input logic v);
        @(negedge clock);
        cfg_load = 1'b0;
        seq_in   = b;
        in_valid = v;
        @(posedge clock);
        #1;
    endtask

    // Feed n bits MSB-first from bits, checking seq_out after each against exp (MSB-first).
    task automatic feed(input string tag, input logic [31:0] bits, input logic [31:0] exp,
                        input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1);
            chk($sformatf("%s_bit%0d", tag, n - i), {31'd0, seq_out}, {31'd0, exp[i]});
        end
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic b, input logic v);
        @(negedge clock);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        seq_in      = b;
        in_valid    = v;
        @(posedge clock);
        #1;
        chk("load_seq_out", {31'd0, seq_out}, 32'd0);
        chk("load_count", {24'd0, match_count}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        seq_in      = 1'b0;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_seq_out", {31'd0, seq_out}, 32'd0);
        chk("rst_count", {24'd0, match_count}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Defaults: overlapping "0100".
        feed("dflt_ovl", 32'b0100100, 32'b0001001, 7);
        chk("dflt_ovl_count", {24'd0, match_count}, 32'd2);

        // Hold while idle.
        load(8'b0100, 4'd4, 1'b1, 1'b0, 1'b0);
        feed("hold_pre", 32'b0100, 32'b0001, 4);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            chk($sformatf("hold_idle%0d", i), {31'd0, seq_out}, 32'd1);
        end
        feed("hold_post", 32'b1, 32'b0, 1);
        chk("hold_count", {24'd0, match_count}, 32'd1);

        // Non-overlapping "0100".
        load(8'b0100, 4'd4, 1'b0, 1'b0, 1'b0);
        feed("novl", 32'b0100100, 32'b0001000, 7);
        chk("novl_count", {24'd0, match_count}, 32'd1);

        // "101" overlapping, then non-overlapping.
        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        feed("p101_ovl", 32'b10101, 32'b00101, 5);
        chk("p101_ovl_count", {24'd0, match_count}, 32'd2);
        load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
        feed("p101_novl", 32'b10101, 32'b00100, 5);
        chk("p101_novl_count", {24'd0, match_count}, 32'd1);

        // len=0 clamps to 1; upper pattern bits ignored.
        load(8'b1010_1011, 4'd0, 1'b1, 1'b0, 1'b0);
        feed("len0", 32'b101, 32'b101, 3);
        // len=15 clamps to 8.
        load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0);
        feed("len15", 32'b1010_0101, 32'b0000_0001, 8);
        // Upper bits 0xF_ ignored with len=4.
        load(8'hF4, 4'd4, 1'b1, 1'b0, 1'b0);
        feed("upper_ign", 32'b0100, 32'b0001, 4);

        // Reset mid-stream: straddling pattern must not match.
        load(8'b0100, 4'd4, 1'b1, 1'b0, 1'b0);
        feed("mid_pre", 32'b0100, 32'b0001, 4);
        feed("mid_part", 32'b010, 32'b000, 3);
        @(negedge clock);
        reset = 1'b1;
        #2;
        chk("mid_rst_seq_out", {31'd0, seq_out}, 32'd0);
        chk("mid_rst_count", {24'd0, match_count}, 32'd0);
        reset = 1'b0;
        feed("mid_post", 32'b0, 32'b0, 1);

        // cfg_load discards the bit on its own edge.
        load(8'b0100, 4'd4, 1'b1, 1'b0, 1'b1);
        feed("load_disc", 32'b100100, 32'b000001, 6);

        // Saturation: five non-overlapping "0100" groups.
        load(8'b0100, 4'd4, 1'b0, 1'b0, 1'b0);
        feed("sat", 32'h44444, 32'h11111, 20);
        chk("sat_count_wide", {24'd0, match_count}, 32'd5);
        chk("sat_count_narrow", {30'd0, match_count_s}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
